// File: rtl/compressor_reduce_seq_if.sv
// Job/result handshake bundle between the partial-product source, the
// reduction sequencer and the downstream carry-propagate stage.
interface compressor_reduce_seq_if #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*WIDTH-1:0]   in_rows;
    logic [4:0]              in_count;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_sum;
    logic [WIDTH-1:0]        out_carry;
    logic [3:0]              out_levels;

    modport master (
        output in_valid, in_rows, in_count, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_levels
    );

    modport slave (
        input  in_valid, in_rows, in_count, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_levels
    );
endinterface

// File: rtl/compressor_reduce_seq.sv
// Multi-cycle carry-save reducer: one shared bank of 3:2 compressor rows is
// applied once per cycle until only a sum/carry pair remains.
module compressor_reduce_seq #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    compressor_reduce_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rows_q  [ROWS];
    logic [WIDTH-1:0] rows_d  [ROWS];
    logic [WIDTH-1:0] reduced [ROWS];
    logic [WIDTH-1:0] sum_g   [ROWS];
    logic [WIDTH-1:0] carry_g [ROWS];
    logic [4:0]       height_q, height_d;
    logic [4:0]       eff_count;
    logic [4:0]       groups, rem, red_height;
    logic [3:0]       levels_q, levels_d;

    assign eff_count  = (bus.in_count > 5'(ROWS)) ? 5'(ROWS) : bus.in_count;
    assign groups     = height_q / 5'd3;
    assign rem        = height_q % 5'd3;
    assign red_height = (groups << 1) + rem;

    // Fixed compressor bank; groups beyond the live height are discarded below.
    always_comb begin
        for (int g = 0; g < ROWS; g++) begin
            sum_g[g]   = '0;
            carry_g[g] = '0;
        end
        for (int g = 0; g < ROWS / 3; g++) begin
            sum_g[g]   = rows_q[3*g] ^ rows_q[3*g+1] ^ rows_q[3*g+2];
            carry_g[g] = ((rows_q[3*g] & rows_q[3*g+1]) |
                          (rows_q[3*g] & rows_q[3*g+2]) |
                          (rows_q[3*g+1] & rows_q[3*g+2])) << 1;
        end
    end

    // Compressed pairs pack to the bottom; leftover row at src lands at src-groups.
    always_comb begin
        for (int j = 0; j < ROWS; j++) begin
            reduced[j] = '0;
            if (j < 2 * int'(groups)) begin
                reduced[j] = (j % 2 == 0) ? sum_g[j/2] : carry_g[j/2];
            end else if (j < 2 * int'(groups) + int'(rem)) begin
                for (int s = j; s < ROWS; s++) begin
                    if (s == j + int'(groups)) begin
                        reduced[j] = rows_q[s];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        height_d = height_q;
        levels_d = levels_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < ROWS; i++) begin
                        rows_d[i] = (i < int'(eff_count)) ? bus.in_rows[WIDTH*i +: WIDTH] : '0;
                    end
                    height_d = eff_count;
                    levels_d = '0;
                    state_d  = (eff_count <= 5'd2) ? DONE : REDUCE;
                end
            end
            REDUCE: begin
                rows_d   = reduced;
                height_d = red_height;
                levels_d = levels_q + 4'd1;
                if (red_height <= 5'd2) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            height_q <= '0;
            levels_q <= '0;
            for (int i = 0; i < ROWS; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            height_q <= height_d;
            levels_q <= levels_d;
            rows_q   <= rows_d;
        end
    end

    // in_ready is masked by rst so nothing is offered while reset is held.
    assign bus.in_ready   = (state_q == IDLE) && !rst;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_sum    = rows_q[0];
    assign bus.out_carry  = rows_q[1];
    assign bus.out_levels = levels_q;
endmodule

// File: tb/tb_compressor_reduce_seq.sv
// Scoreboard bench for compressor_reduce_seq: expected totals/levels queued
// at job launch, compared when the result handshake completes.
module tb_compressor_reduce_seq;
    localparam int WIDTH = 32;
    localparam int ROWS  = 12;

    typedef struct {
        logic [WIDTH-1:0] total;
        logic [3:0]       levels;
        bit               exact;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] carry;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    compressor_reduce_seq_if #(.WIDTH(WIDTH), .ROWS(ROWS)) bus ();

    compressor_reduce_seq #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int levelsFor(input int h);
        int l = 0;
        while (h > 2) begin
            h = 2 * (h / 3) + h % 3;
            l++;
        end
        return l;
    endfunction

    task automatic applyStimulus(input logic [ROWS*WIDTH-1:0] rows, input logic [4:0] count,
                                 input bit exact, input logic [WIDTH-1:0] esum,
                                 input logic [WIDTH-1:0] ecarry, output int exp_lat);
        exp_t e;
        int   eff;
        int   waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready_wait", 32'(bus.in_ready), 32'd1);
        eff = (int'(count) > ROWS) ? ROWS : int'(count);
        e.total = '0;
        for (int i = 0; i < eff; i++) e.total += rows[WIDTH*i +: WIDTH];
        e.levels = 4'(levelsFor(eff));
        e.exact  = exact;
        e.sum    = esum;
        e.carry  = ecarry;
        sb.push_back(e);
        exp_lat = 1 + levelsFor(eff);
        bus.in_valid = 1'b1;
        bus.in_rows  = rows;
        bus.in_count = count;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitOutput(input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 60);
        checkOutput("latency", 32'(lat), 32'(exp_lat));
    endtask

    // Completed handshakes retire the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sum_plus_carry", bus.out_sum + bus.out_carry, mon_e.total);
                checkOutput("levels", 32'(bus.out_levels), 32'(mon_e.levels));
                if (mon_e.exact) begin
                    checkOutput("out_sum", bus.out_sum, mon_e.sum);
                    checkOutput("out_carry", bus.out_carry, mon_e.carry);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ROWS*WIDTH-1:0] rows;
        logic [WIDTH-1:0]      hold_sum, hold_carry;
        logic [3:0]            hold_levels;
        int                    lat;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_rows  = '0;
        bus.in_count = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_sum", bus.out_sum, 32'd0);
        checkOutput("rst_out_carry", bus.out_carry, 32'd0);
        checkOutput("rst_out_levels", 32'(bus.out_levels), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        $display("[TB] twelve rows of one");
        for (int i = 0; i < ROWS; i++) rows[WIDTH*i +: WIDTH] = 32'd1;
        applyStimulus(rows, 5'd12, 1'b0, '0, '0, lat);
        checkOutput("twelve_row_lat_model", 32'(lat), 32'd6);
        waitOutput(lat);
        @(negedge clk);
        checkOutput("in_ready_after_consume", 32'(bus.in_ready), 32'd1);

        $display("[TB] two rows pass straight through");
        for (int i = 0; i < ROWS; i++) rows[WIDTH*i +: WIDTH] = 32'hFF;
        rows[WIDTH*0 +: WIDTH] = 32'h5;
        rows[WIDTH*1 +: WIDTH] = 32'h7;
        applyStimulus(rows, 5'd2, 1'b1, 32'h5, 32'h7, lat);
        waitOutput(lat);

        $display("[TB] three all-ones rows");
        for (int i = 0; i < ROWS; i++) rows[WIDTH*i +: WIDTH] = 32'hFFFFFFFF;
        applyStimulus(rows, 5'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, lat);
        waitOutput(lat);

        $display("[TB] backpressure with toggling input");
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < ROWS; i++) rows[WIDTH*i +: WIDTH] = $urandom();
        applyStimulus(rows, 5'd5, 1'b0, '0, '0, lat);
        waitOutput(lat);
        hold_sum    = bus.out_sum;
        hold_carry  = bus.out_carry;
        hold_levels = bus.out_levels;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (c % 2 == 0);
            for (int i = 0; i < ROWS; i++) bus.in_rows[WIDTH*i +: WIDTH] = $urandom();
            bus.in_count = 5'd3;
            @(negedge clk);
            checkOutput("hold_sum", bus.out_sum, hold_sum);
            checkOutput("hold_carry", bus.out_carry, hold_carry);
            checkOutput("hold_levels", 32'(bus.out_levels), 32'(hold_levels));
            checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("post_bp_in_ready", 32'(bus.in_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("no_capture", 32'(bus.out_valid), 32'd0);
        end

        $display("[TB] reset during third reduce pass");
        for (int i = 0; i < ROWS; i++) rows[WIDTH*i +: WIDTH] = $urandom();
        applyStimulus(rows, 5'd12, 1'b0, '0, '0, lat);
        void'(sb.pop_back());
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_out_sum", bus.out_sum, 32'd0);
        checkOutput("abort_out_carry", bus.out_carry, 32'd0);
        checkOutput("abort_out_levels", 32'(bus.out_levels), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        rows = '0;
        for (int i = 0; i < 4; i++) rows[WIDTH*i +: WIDTH] = 32'(i + 1);
        applyStimulus(rows, 5'd4, 1'b0, '0, '0, lat);
        checkOutput("four_row_lat_model", 32'(lat), 32'd3);
        waitOutput(lat);

        $display("[TB] edge counts");
        for (int i = 0; i < ROWS; i++) rows[WIDTH*i +: WIDTH] = $urandom();
        applyStimulus(rows, 5'd0, 1'b1, 32'd0, 32'd0, lat);
        waitOutput(lat);
        applyStimulus(rows, 5'd20, 1'b0, '0, '0, lat);
        checkOutput("clamp_lat_model", 32'(lat), 32'd6);
        waitOutput(lat);

        $display("[TB] random jobs");
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < ROWS; i++) rows[WIDTH*i +: WIDTH] = $urandom();
            applyStimulus(rows, 5'($urandom_range(0, ROWS)), 1'b0, '0, '0, lat);
            waitOutput(lat);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/compressor_reduce_seq.md
# compressor_reduce_seq

Multi-cycle carry-save reduction sequencer for the modular-squaring datapath. It accepts up to ROWS partial-product rows and reuses one shared bank of 3:2 compressor rows once per cycle. Each pass reduces the row height until two rows remain. It then presents the result as a sum/carry pair to the downstream carry-propagate stage over a valid/ready handshake, which lets a small compressor array stand in for a full-depth tree.

## Interface
- WIDTH, 32: bit width of every row and of both outputs.
- ROWS, 12: maximum number of input rows; legal range 3..16.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input rows and count are valid.
- in_ready  output  1  block is idle and can accept a new job.
- in_rows  input  ROWS*WIDTH  row i occupies bits [WIDTH*(i+1)-1 : WIDTH*i].
- in_count  input  5  number of valid rows, starting at row 0.
- out_valid  output  1  out_sum and out_carry hold the final result.
- out_ready  input  1  downstream consumes the result.
- out_sum  output  WIDTH  final row 0.
- out_carry  output  WIDTH  final row 1.
- out_levels  output  4  number of reduction passes performed for this job.

## Operation
- **FSM states:** IDLE, REDUCE, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid & in_ready, load all ROWS rows into the row buffer. Rows at index ≥ eff_count are forced to zero.
  - Set height h=eff_count and clear the level counter.
  - If h≤2, go to DONE. Otherwise go to REDUCE.
- **eff_count:**
  - eff_count = min(in_count, ROWS).
  - in_count=0 gives h=0; the output is 0/0.
- **REDUCE:** one pass per cycle.
  - Group rows 3g, 3g+1, 3g+2 for g = 0..floor(h/3)-1.
  - Each group produces sum = a^b^c and carry = ((a&b)|(a&c)|(b&c))<<1. The shifted-out MSB is dropped, so all arithmetic is mod 2^WIDTH.
  - New row 2g = sum; new row 2g+1 = carry.
  - The h mod 3 leftover rows follow in original order.
  - All rows at index ≥ new height are zeroed.
  - New height h' = 2*floor(h/3) + (h mod 3).
  - Increment the level counter. When h'≤2, go to DONE.
- **DONE:**
  - out_valid=1; out_sum=row 0, out_carry=row 1, out_levels=level counter.
  - On out_valid & out_ready, go to IDLE.
- **Handshake rules:**
  - in_ready is 0 outside IDLE. in_valid in REDUCE/DONE is ignored and the input is not captured.
  - in_ready does not depend combinationally on out_ready; there is no job overlap.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- **Invariant:** out_sum + out_carry ≡ Σ (valid input rows) mod 2^WIDTH.
- **Reset:**
  - State IDLE; out_valid=0; out_sum=0; out_carry=0; out_levels=0.
  - in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
  - Reset in any state, including mid-REDUCE or DONE, aborts the job without producing output.

## Timing
- Accept in cycle t with L passes required: out_valid is first high in cycle t+1+L.
- L=0 when eff_count≤2, giving out_valid at t+1.
- Pass count by height (ROWS=12): 12→8→6→4→3→2, so L=5 and out_valid at t+6.
- Other heights:
  - h=3: L=1.
  - h=4: L=2.
  - h=5 or 6: L=3.
  - h=7, 8 or 9: L=4.
  - h=10..13: L=5.
  - h=14..16: L=6.
- When out_ready=1 in the first DONE cycle, in_ready is high in the next cycle. Minimum job spacing is therefore L+2 cycles.
- Row buffer, level counter and outputs are registered. Only in_ready and out_valid decode directly from the state register.

## Test plan
- 12 rows of 0x00000001, in_count=12, out_ready=1 → out_valid at t+6; out_sum+out_carry=12; out_levels=5; in_ready high at t+7.
- in_count=2, rows 0x5, 0x7, rest 0xFF → out_valid at t+1; out_sum=0x5, out_carry=0x7, out_levels=0. Rows 2..11 are ignored.
- 3 rows of 0xFFFFFFFF → out_levels=1; out_sum=0xFFFFFFFF, out_carry=0xFFFFFFFE; sum mod 2^32 = 0xFFFFFFFD.
- Job completes with out_ready held low for 10 cycles while in_valid toggles with new data → outputs unchanged and in_ready=0 throughout; the result is consumed on the first out_ready=1 cycle; the toggled input is never captured.
- rst asserted in the 3rd REDUCE cycle → next cycle state IDLE, out_valid=0, outputs 0, in_ready=1 after release. A following 4-row job with rows 1,2,3,4 → sum 10, out_levels=2.
- Edge counts:
  - in_count=0 → out 0/0, L=0.
  - in_count=20 with ROWS=12 → clamped to 12, L=5.
  - 1000 random jobs (in_count 0..12) → invariant holds; out_levels matches the formula.
